// File: rtl/mult_pipe_scaled_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pipe_scaled_pkg
// Description : Shared constants and saturation-bound helpers for the
//               pipelined shift-add multiplier. The width constants describe
//               the default configuration; parameterised instances derive
//               their own widths from WA/WB.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pipe_scaled_pkg;

    // Default operand widths
    localparam int c_WA_DEF = 8;
    localparam int c_WB_DEF = 8;

    // Full-product width and pipeline latency at the default configuration
    localparam int c_P   = c_WA_DEF + c_WB_DEF;
    localparam int c_LAT = c_WB_DEF + 1;

    // Working width for saturation compares. Wide enough to hold any
    // P+1-bit intermediate as a signed value for P up to 64.
    localparam int c_SAT_W = 66;

    // Largest representable result for a given output width and mode
    function automatic logic signed [c_SAT_W-1:0] sat_max(input int width,
                                                          input logic is_signed);
        if (is_signed)
            return (c_SAT_W'(1) << (width - 1)) - c_SAT_W'(1);
        else
            return (c_SAT_W'(1) << width) - c_SAT_W'(1);
    endfunction

    // Smallest representable result for a given output width and mode
    function automatic logic signed [c_SAT_W-1:0] sat_min(input int width,
                                                          input logic is_signed);
        if (is_signed)
            return -(c_SAT_W'(1) << (width - 1));
        else
            return '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : mult_pipe_stage
// Description : One registered shift-add/subtract stage of the multiplier.
//               Consumes the lowest remaining multiplier bit and adds (or, in
//               the MSB stage of a signed sample, subtracts) the multiplicand
//               shifted by the stage index.
// Ports       : clk, rst, ce          - clock, sync reset, clock enable
//               i_valid / o_valid     - sample valid
//               i_signed / o_signed   - two's-complement mode of the sample
//               i_acc / o_acc         - partial product (P bits, mod 2^P)
//               i_a_ext / o_a_ext     - extended multiplicand (unshifted)
//               i_b / o_b             - remaining multiplier bits, LSB next
//               i_tag / o_tag         - sideband tag
// Revision    : 1.0 - initial release
// ============================================================================
module mult_pipe_stage
    import mult_pipe_scaled_pkg::*;
#(
    parameter int P     = 16,
    parameter int WB    = 8,
    parameter int TAG_W = 4,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             i_valid,
    input  logic             i_signed,
    input  logic [P-1:0]     i_acc,
    input  logic [P-1:0]     i_a_ext,
    input  logic [WB-1:0]    i_b,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    output logic             o_signed,
    output logic [P-1:0]     o_acc,
    output logic [P-1:0]     o_a_ext,
    output logic [WB-1:0]    o_b,
    output logic [TAG_W-1:0] o_tag
);

    // The multiplier MSB carries negative weight in two's complement
    localparam bit c_LAST = (IDX == WB - 1);

    logic [P-1:0] w_addend;
    logic [P-1:0] w_acc_nxt;
    logic         w_sub;

    assign w_addend  = i_b[0] ? (i_a_ext << IDX) : '0;
    assign w_sub     = c_LAST && i_signed;
    assign w_acc_nxt = w_sub ? (i_acc - w_addend) : (i_acc + w_addend);

    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid  <= 1'b0;
            o_signed <= 1'b0;
            o_acc    <= '0;
            o_a_ext  <= '0;
            o_b      <= '0;
            o_tag    <= '0;
        end else if (ce) begin
            o_valid  <= i_valid;
            o_signed <= i_signed;
            o_acc    <= w_acc_nxt;
            o_a_ext  <= i_a_ext;
            o_b      <= i_b >> 1;
            o_tag    <= i_tag;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_pipe_scaled.sv
`default_nettype none
// ============================================================================
// Module      : mult_pipe_scaled
// Description : Fully pipelined shift-add multiplier (one multiplier bit per
//               stage, one sample per ce-active cycle) followed by a
//               round-half-up scaling and saturation output stage.
//               Latency is WB+1 ce-active cycles.
// Ports       : clk, rst, ce          - clock, sync reset, clock enable
//               in_valid, in_signed   - sample valid / two's-complement mode
//               a [WA], b [WB]        - multiplicand / multiplier
//               in_tag [TAG_W]        - sideband travelling with the sample
//               out_valid             - result valid
//               result [OUT_W]        - scaled, rounded, saturated product
//               sat                   - result was clipped
//               out_tag [TAG_W]       - tag of the sample in result
// Revision    : 1.0 - initial release
// ============================================================================
module mult_pipe_scaled
    import mult_pipe_scaled_pkg::*;
#(
    parameter int WA    = c_WA_DEF,
    parameter int WB    = c_WB_DEF,
    parameter int OUT_W = 16,
    parameter int SHIFT = 0,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             in_valid,
    input  logic             in_signed,
    input  logic [WA-1:0]    a,
    input  logic [WB-1:0]    b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [OUT_W-1:0] result,
    output logic             sat,
    output logic [TAG_W-1:0] out_tag
);

    localparam int c_PW  = WA + WB;
    // Rounding constant 2^(SHIFT-1); zero when no scaling is applied
    localparam int c_RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [c_PW:0] c_RND = (SHIFT > 0) ? ((c_PW + 1)'(1) << c_RSH) : '0;

    // ------------------------------------------------------------------
    // Shift-add pipeline. Index 0 is the pipeline input, index WB the
    // output of the last shift-add stage.
    // ------------------------------------------------------------------
    logic             w_vld  [0:WB];
    logic             w_sgn  [0:WB];
    logic [c_PW-1:0]  w_acc  [0:WB];
    logic [c_PW-1:0]  w_aext [0:WB];
    logic [WB-1:0]    w_b    [0:WB];
    logic [TAG_W-1:0] w_tag  [0:WB];

    assign w_vld[0]  = in_valid;
    assign w_sgn[0]  = in_signed;
    assign w_acc[0]  = '0;
    assign w_aext[0] = in_signed ? {{WB{a[WA-1]}}, a} : {{WB{1'b0}}, a};
    assign w_b[0]    = b;
    assign w_tag[0]  = in_tag;

    generate
        for (genvar i = 0; i < WB; i++) begin : g_stage
            mult_pipe_stage #(
                .P     (c_PW),
                .WB    (WB),
                .TAG_W (TAG_W),
                .IDX   (i)
            ) u_stage (
                .clk      (clk),
                .rst      (rst),
                .ce       (ce),
                .i_valid  (w_vld[i]),
                .i_signed (w_sgn[i]),
                .i_acc    (w_acc[i]),
                .i_a_ext  (w_aext[i]),
                .i_b      (w_b[i]),
                .i_tag    (w_tag[i]),
                .o_valid  (w_vld[i+1]),
                .o_signed (w_sgn[i+1]),
                .o_acc    (w_acc[i+1]),
                .o_a_ext  (w_aext[i+1]),
                .o_b      (w_b[i+1]),
                .o_tag    (w_tag[i+1])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output stage: round, scale, saturate
    // ------------------------------------------------------------------
    logic                      w_sgn_f;
    logic [c_PW:0]             w_ext;
    logic [c_PW:0]             w_sum;
    logic [c_PW:0]             w_shr_s;
    logic [c_PW:0]             w_shr_u;
    logic [c_PW:0]             w_shr;
    logic signed [c_SAT_W-1:0] w_t;
    logic signed [c_SAT_W-1:0] w_max;
    logic signed [c_SAT_W-1:0] w_min;
    logic                      w_hi;
    logic                      w_lo;
    logic [OUT_W-1:0]          w_res;
    logic                      w_sat;

    assign w_sgn_f = w_sgn[WB];

    // One extra bit so the rounding add can never wrap in either mode
    assign w_ext = w_sgn_f ? {w_acc[WB][c_PW-1], w_acc[WB]} : {1'b0, w_acc[WB]};
    assign w_sum = w_ext + c_RND;

    // Kept as two separate shifts: mixing them in one ?: would make the
    // expression unsigned and silently turn >>> into a logical shift.
    assign w_shr_s = $signed(w_sum) >>> SHIFT;
    assign w_shr_u = w_sum >> SHIFT;
    assign w_shr   = w_sgn_f ? w_shr_s : w_shr_u;

    assign w_t = w_sgn_f ? {{(c_SAT_W - c_PW - 1){w_shr[c_PW]}}, w_shr}
                         : {{(c_SAT_W - c_PW - 1){1'b0}}, w_shr};

    assign w_max = sat_max(OUT_W, w_sgn_f);
    assign w_min = sat_min(OUT_W, w_sgn_f);

    always_comb begin
        w_hi  = 1'b0;
        w_lo  = 1'b0;
        w_res = w_t[OUT_W-1:0];
        if (w_t > w_max) begin
            w_hi  = 1'b1;
            w_res = w_max[OUT_W-1:0];
        end else if (w_t < w_min) begin
            w_lo  = 1'b1;
            w_res = w_min[OUT_W-1:0];
        end
        w_sat = w_hi | w_lo;
    end

    // Result fields only move for a valid sample so they keep the last
    // result through bubbles; out_valid tracks the valid bit every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            sat       <= 1'b0;
            out_tag   <= '0;
        end else if (ce) begin
            out_valid <= w_vld[WB];
            if (w_vld[WB]) begin
                result  <= w_res;
                sat     <= w_sat;
                out_tag <= w_tag[WB];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_pipe_scaled.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_pipe_scaled
// Description : Self-checking bench for mult_pipe_scaled. Three instances
//               (16-bit/no shift, 8-bit/shift 7, 8-bit/no shift) share one
//               stimulus stream; a queue holds the expected results of every
//               accepted sample for all three and is popped as results emerge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_pipe_scaled;

    localparam int c_LAT = 9;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic       in_valid;
    logic       in_signed;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] in_tag;

    logic        ov_a, ov_b, ov_c;
    logic [15:0] res_a;
    logic [7:0]  res_b, res_c;
    logic        sat_a, sat_b, sat_c;
    logic [3:0]  tag_a, tag_b, tag_c;

    always #5 clk = ~clk;

    mult_pipe_scaled #(.WA(8), .WB(8), .OUT_W(16), .SHIFT(0), .TAG_W(4)) u_dut_a (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_signed(in_signed),
        .a(a), .b(b), .in_tag(in_tag),
        .out_valid(ov_a), .result(res_a), .sat(sat_a), .out_tag(tag_a));

    mult_pipe_scaled #(.WA(8), .WB(8), .OUT_W(8), .SHIFT(7), .TAG_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_signed(in_signed),
        .a(a), .b(b), .in_tag(in_tag),
        .out_valid(ov_b), .result(res_b), .sat(sat_b), .out_tag(tag_b));

    mult_pipe_scaled #(.WA(8), .WB(8), .OUT_W(8), .SHIFT(0), .TAG_W(4)) u_dut_c (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_signed(in_signed),
        .a(a), .b(b), .in_tag(in_tag),
        .out_valid(ov_c), .result(res_c), .sat(sat_c), .out_tag(tag_c));

    typedef struct {
        logic [2:0][15:0] res;
        logic [2:0]       s;
        logic [3:0]       tag;
        int               stamp;
    } exp_t;

    exp_t sb[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int ce_cnt = 0;

    int cfg_ow [3] = '{16, 8, 8};
    int cfg_sh [3] = '{0, 7, 0};

    logic        pv [3];
    logic [15:0] pr [3];
    logic        ps [3];
    logic [3:0]  pt [3];

    // Reference: exact integer product, round-half-up scaling, clamp
    function automatic void model(input logic [7:0] ma, input logic [7:0] mb,
                                  input logic sg, input int ow, input int sh,
                                  output logic [15:0] r, output logic s);
        longint p, t, mx, mn;
        if (sg) p = longint'($signed(ma)) * longint'($signed(mb));
        else    p = longint'(ma) * longint'(mb);
        if (sh > 0) t = (p + (longint'(1) <<< (sh - 1))) >>> sh;
        else        t = p;
        mx = sg ? (longint'(1) <<< (ow - 1)) - 1 : (longint'(1) <<< ow) - 1;
        mn = sg ? -(longint'(1) <<< (ow - 1)) : 0;
        s = 1'b0;
        if (t > mx) begin t = mx; s = 1'b1; end
        else if (t < mn) begin t = mn; s = 1'b1; end
        r = 16'(t & ((longint'(1) <<< ow) - 1));
    endfunction

    // Advance one clock and compare outputs at the following negedge
    task automatic tick();
        logic        ce_now, rst_now;
        logic        av [3];
        logic [15:0] ar [3];
        logic        as [3];
        logic [3:0]  at [3];
        exp_t        e;
        ce_now  = ce;
        rst_now = rst;
        @(posedge clk);
        if (rst_now) sb.delete();
        else if (ce_now) ce_cnt++;
        @(negedge clk);
        av = '{ov_a, ov_b, ov_c};
        ar = '{res_a, {8'h00, res_b}, {8'h00, res_c}};
        as = '{sat_a, sat_b, sat_c};
        at = '{tag_a, tag_b, tag_c};
        if (rst_now) begin
            for (int d = 0; d < 3; d++) begin
                n_cmp++;
                if ({av[d], ar[d], as[d], at[d]} !== 22'd0) begin
                    n_fail++;
                    $display("FAIL reset_clear dut%0d: got v=%b r=%h s=%b t=%h, need all 0",
                             d, av[d], ar[d], as[d], at[d]);
                end
            end
        end else if (!ce_now) begin
            for (int d = 0; d < 3; d++) begin
                n_cmp++;
                if (av[d] !== pv[d] || ar[d] !== pr[d] || as[d] !== ps[d] || at[d] !== pt[d]) begin
                    n_fail++;
                    $display("FAIL stall_hold dut%0d: got v=%b r=%h s=%b t=%h, need v=%b r=%h s=%b t=%h",
                             d, av[d], ar[d], as[d], at[d], pv[d], pr[d], ps[d], pt[d]);
                end
            end
        end else if (av[0] === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got out_valid=1 r=%h t=%h, need no result", ar[0], at[0]);
            end else begin
                e = sb.pop_front();
                n_cmp++;
                if (ce_cnt - e.stamp !== c_LAT) begin
                    n_fail++;
                    $display("FAIL latency: got %0d ce cycles, need %0d", ce_cnt - e.stamp, c_LAT);
                end
                for (int d = 0; d < 3; d++) begin
                    n_cmp++;
                    if (av[d] !== 1'b1 || ar[d] !== e.res[d] || as[d] !== e.s[d] || at[d] !== e.tag) begin
                        n_fail++;
                        $display("FAIL result dut%0d: got v=%b r=%h s=%b t=%h, need v=1 r=%h s=%b t=%h",
                                 d, av[d], ar[d], as[d], at[d], e.res[d], e.s[d], e.tag);
                    end
                end
            end
        end else begin
            for (int d = 1; d < 3; d++) begin
                n_cmp++;
                if (av[d] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL valid_align dut%0d: got out_valid=%b, need 0", d, av[d]);
                end
            end
        end
        pv = av; pr = ar; ps = as; pt = at;
    endtask

    // Present one accepted sample (ce=1) and record its expected results
    task automatic send(input logic [7:0] sa, input logic [7:0] sbv,
                        input logic sg, input logic [3:0] tg);
        exp_t e;
        ce = 1'b1; in_valid = 1'b1; in_signed = sg; a = sa; b = sbv; in_tag = tg;
        for (int d = 0; d < 3; d++) begin
            logic [15:0] r;
            logic        s;
            model(sa, sbv, sg, cfg_ow[d], cfg_sh[d], r, s);
            e.res[d] = r;
            e.s[d]   = s;
        end
        e.tag   = tg;
        e.stamp = ce_cnt;
        sb.push_back(e);
        tick();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    // Stall with a garbage sample on the inputs that must not be taken
    task automatic stall(input int n);
        ce = 1'b0;
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
            in_signed = 1'($urandom); in_tag = 4'($urandom);
            tick();
        end
        in_valid = 1'b0;
        ce = 1'b1;
    endtask

    task automatic drain(input string name);
        ce = 1'b1;
        idle(c_LAT + 3);
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_%s: got %0d results outstanding, need 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ce = 1'b1;
        tick(); tick();
        rst = 1'b0;
        send(8'd10, 8'd20, 1'b0, 4'd1);
        send(8'd30, 8'd40, 1'b1, 4'd2);
        send(8'd50, 8'd60, 1'b0, 4'd3);
        idle(2);
        // Reset with ce low must still clear everything
        ce = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; ce = 1'b1;
        idle(c_LAT + 3);
    endtask

    task automatic test_unsigned();
        send(8'd255, 8'd255, 1'b0, 4'd5);
        drain("unsigned");
    endtask

    task automatic test_back_to_back();
        send(8'h80, 8'hFF, 1'b1, 4'd6);
        send(8'h80, 8'h80, 1'b1, 4'd7);
        send(8'h7F, 8'h80, 1'b1, 4'd8);
        send(8'h80, 8'hFF, 1'b0, 4'd9);
        drain("back_to_back");
    endtask

    task automatic test_stall();
        send(8'h80, 8'hFF, 1'b1, 4'd6);
        send(8'h80, 8'h80, 1'b1, 4'd7);
        stall(3);
        send(8'h7F, 8'h80, 1'b1, 4'd8);
        send(8'h80, 8'hFF, 1'b0, 4'd9);
        idle(6);
        stall(3);
        drain("stall");
    endtask

    task automatic test_scaled();
        send(8'd64,  8'd64,  1'b1, 4'd1);
        send(8'd127, 8'd127, 1'b1, 4'd2);
        send(8'h80,  8'd127, 1'b1, 4'd3);
        send(8'h80,  8'h80,  1'b1, 4'd4);
        send(8'd15,  8'd17,  1'b0, 4'd5);
        send(8'd16,  8'd16,  1'b0, 4'd6);
        send(8'd0,   8'd200, 1'b0, 4'd7);
        drain("scaled");
    endtask

    task automatic test_random();
        for (int k = 0; k < 60; k++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 2) stall(1);
            else if (sel < 3) idle(1);
            else send(8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom));
        end
        drain("random");
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; in_valid = 1'b0; in_signed = 1'b0;
        a = '0; b = '0; in_tag = '0;
        @(negedge clk);
        test_reset();
        test_unsigned();
        test_back_to_back();
        test_stall();
        test_scaled();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
